// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: gives the loader exclusive access during boot, then arbitrates fetch and loader per cycle.
// Optional IMEM_ARB_RR_EN selects round-robin on contention; the default build uses fixed fetch priority.
module imem_arbiter #(
  parameter int          DEPTH    = 256,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  input  logic          boot_done,
  output logic          core_run,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  output logic          err
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_F    = 2'd1;
  localparam logic [1:0] OWN_L    = 2'd2;

  logic [0:0]  state;
  logic [1:0]  owner;
  logic        rsp_fault;
  logic        err_q;
  logic        f_win;
  logic        l_win;
  logic        active;
  logic        sel_fault;
  logic [31:0] sel_addr;

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

`ifdef IMEM_ARB_RR_EN
  // Records the winner of the last contested cycle; the other side is favoured next time.
  logic last_l;
`endif

  // Grants are gated by rst_n so they read as idle while reset is held.
  always_comb begin
    f_win = 1'b0;
    l_win = 1'b0;
    if (rst_n) begin
      if (state == BOOT) begin
        l_win = l_req;
      end else if (f_req && l_req) begin
`ifdef IMEM_ARB_RR_EN
        f_win = last_l;
        l_win = !last_l;
`else
        f_win = 1'b1;
`endif
      end else begin
        f_win = f_req;
        l_win = l_req;
      end
    end
  end

  always_comb begin
    sel_addr  = l_win ? l_addr : f_addr;
    active    = f_win || l_win;
    sel_fault = active && addr_fault(sel_addr);
  end

  assign f_gnt    = f_win;
  assign l_gnt    = l_win;
  assign core_run = (state == RUN);
  assign m_en     = active && !sel_fault;
  assign m_we     = l_win && l_we && !sel_fault;
  assign m_addr   = active ? sel_addr[AW+1:2] : '0;
  assign m_wdata  = l_win ? l_wdata : '0;

  assign f_rvalid = (owner == OWN_F);
  assign l_rvalid = (owner == OWN_L);
  assign f_rdata  = rsp_fault ? NOP_WORD : m_rdata;
  assign l_rdata  = rsp_fault ? NOP_WORD : m_rdata;
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      owner     <= OWN_NONE;
      rsp_fault <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state == BOOT && boot_done)
        state <= RUN;
      if (l_win)
        owner <= OWN_L;
      else if (f_win)
        owner <= OWN_F;
      else
        owner <= OWN_NONE;
      rsp_fault <= sel_fault;
      if (sel_fault)
        err_q <= 1'b1;
    end
  end

`ifdef IMEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_l <= 1'b0;
    else if (state == RUN && f_req && l_req)
      last_l <= l_win;
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural synchronous-read memory.
// Contention expectations follow IMEM_ARB_RR_EN when it is defined for the build.
module tb_imem_arbiter;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk;
  logic          rst_n;
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          boot_done;
  logic          core_run;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          err;

  logic [31:0] mem [0:DEPTH-1];

  int checks   = 0;
  int failures = 0;

  imem_arbiter #(.DEPTH(DEPTH), .AW(AW), .NOP_WORD(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .boot_done(boot_done), .core_run(core_run),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we)
        mem[m_addr] <= m_wdata;
      m_rdata <= mem[m_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_f;
    logic        prev_f;
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
    l_addr = '0; l_wdata = '0; boot_done = 1'b0; m_rdata = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      mem[i] = 32'hA000_0000 | i;

    // Reset state
    repeat (2) tick;
    chk("rst_core_run", core_run, 0);
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    rst_n = 1'b1;
    tick;

    // Boot load with fetch held off
    f_req = 1'b1; f_addr = 32'h0;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'h00100093;
    #1;
    chk("boot0_f_gnt", f_gnt, 0);
    chk("boot0_l_gnt", l_gnt, 1);
    chk("boot0_core_run", core_run, 0);
    chk("boot0_m_en", m_en, 1);
    chk("boot0_m_we", m_we, 1);
    chk("boot0_m_addr", m_addr, 0);
    chk("boot0_m_wdata", m_wdata, 32'h00100093);
    tick;
    chk("boot0_l_rvalid", l_rvalid, 1);
    chk("boot0_f_rvalid", f_rvalid, 0);
    l_addr = 32'h4; l_wdata = 32'h00200113;
    #1;
    chk("boot1_f_gnt", f_gnt, 0);
    chk("boot1_l_gnt", l_gnt, 1);
    chk("boot1_m_addr", m_addr, 1);
    tick;
    chk("boot1_l_rvalid", l_rvalid, 1);
    l_req = 1'b0; l_we = 1'b0;
    #1;
    chk("boot_idle_f_gnt", f_gnt, 0);
    chk("boot_idle_l_gnt", l_gnt, 0);
    tick;
    chk("boot_idle_l_rvalid", l_rvalid, 0);
    boot_done = 1'b1;
    #1;
    chk("bootdone_f_gnt", f_gnt, 0);
    chk("bootdone_core_run", core_run, 0);
    tick;
    boot_done = 1'b0;
    #1;
    chk("run_core_run", core_run, 1);
    chk("run_f_gnt", f_gnt, 1);
    chk("run_m_en", m_en, 1);
    chk("run_m_we", m_we, 0);
    chk("run_m_addr", m_addr, 0);
    tick;
    chk("run_f_rvalid", f_rvalid, 1);
    chk("run_f_rdata", f_rdata, 32'h00100093);

    // Back-to-back fetch: 0x4 then 0x8 follow the 0x0 fetch with no bubble
    f_addr = 32'h4;
    #1;
    chk("b2b1_f_gnt", f_gnt, 1);
    tick;
    chk("b2b1_f_rvalid", f_rvalid, 1);
    chk("b2b1_f_rdata", f_rdata, 32'h00200113);
    f_addr = 32'h8;
    #1;
    chk("b2b2_f_gnt", f_gnt, 1);
    chk("b2b2_m_addr", m_addr, 2);
    tick;
    chk("b2b2_f_rvalid", f_rvalid, 1);
    chk("b2b2_f_rdata", f_rdata, 32'hA000_0002);
    f_req = 1'b0;
    tick;
    chk("b2b_end_f_rvalid", f_rvalid, 0);

    // Contention for four cycles
    f_req = 1'b1; f_addr = 32'hC;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
    prev_f = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      #1;
`ifdef IMEM_ARB_RR_EN
      exp_f = (k % 2 == 1) ? 32'd1 : 32'd0;
`else
      exp_f = 32'd1;
`endif
      chk($sformatf("cont%0d_f_gnt", k), f_gnt, exp_f);
      chk($sformatf("cont%0d_l_gnt", k), l_gnt, exp_f ^ 32'd1);
      prev_f = exp_f[0];
      tick;
      chk($sformatf("cont%0d_f_rvalid", k), f_rvalid, prev_f);
      chk($sformatf("cont%0d_l_rvalid", k), l_rvalid, !prev_f);
      if (prev_f)
        chk($sformatf("cont%0d_f_rdata", k), f_rdata, 32'hA000_0003);
      else
        chk($sformatf("cont%0d_l_rdata", k), l_rdata, 32'hA000_0004);
    end
    f_req = 1'b0; l_req = 1'b0;
    tick;
    chk("cont_end_f_rvalid", f_rvalid, 0);
    chk("cont_end_l_rvalid", l_rvalid, 0);
    chk("pre_fault_err", err, 0);

    // Misaligned fetch
    f_req = 1'b1; f_addr = 32'h2;
    #1;
    chk("fault_f_gnt", f_gnt, 1);
    chk("fault_f_m_en", m_en, 0);
    tick;
    chk("fault_f_rvalid", f_rvalid, 1);
    chk("fault_f_rdata", f_rdata, 32'h00000013);
    chk("fault_f_err", err, 1);
    f_req = 1'b0;

    // Out-of-range loader write
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h400; l_wdata = 32'hDEAD_BEEF;
    #1;
    chk("fault_l_gnt", l_gnt, 1);
    chk("fault_l_m_en", m_en, 0);
    chk("fault_l_m_we", m_we, 0);
    tick;
    chk("fault_l_rvalid", l_rvalid, 1);
    chk("fault_l_err", err, 1);
    l_req = 1'b0; l_we = 1'b0;
    f_req = 1'b1; f_addr = 32'h0;
    tick;
    chk("post_fault_f_rdata", f_rdata, 32'h00100093);
    chk("post_fault_err", err, 1);

    // Reset asserted in the cycle after a grant
    f_addr = 32'h4;
    #1;
    chk("rstmid_f_gnt", f_gnt, 1);
    tick;
    rst_n = 1'b0;
    #1;
    chk("rstmid_f_rvalid", f_rvalid, 0);
    chk("rstmid_core_run", core_run, 0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("rstrel_f_rvalid", f_rvalid, 0);
    chk("rstrel_core_run", core_run, 0);
    chk("rstrel_f_gnt", f_gnt, 0);
    chk("rstrel_err", err, 0);
    tick;
    chk("rstrel2_f_rvalid", f_rvalid, 0);

    // boot_done together with a loader write
    f_addr = 32'h8;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h8; l_wdata = 32'h1234_5678;
    boot_done = 1'b1;
    #1;
    chk("edge_l_gnt", l_gnt, 1);
    chk("edge_f_gnt", f_gnt, 0);
    chk("edge_m_we", m_we, 1);
    tick;
    boot_done = 1'b0; l_req = 1'b0; l_we = 1'b0;
    chk("edge_l_rvalid", l_rvalid, 1);
    chk("edge_core_run", core_run, 1);
    #1;
    chk("edge_f_gnt_next", f_gnt, 1);
    chk("edge_m_addr", m_addr, 2);
    tick;
    chk("edge_f_rvalid", f_rvalid, 1);
    chk("edge_f_rdata", f_rdata, 32'h1234_5678);
    f_req = 1'b0;

    // boot_done in RUN has no effect
    boot_done = 1'b1;
    tick;
    boot_done = 1'b0;
    tick;
    chk("run_bootdone_core_run", core_run, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port, synchronous-read instruction memory between the core's fetch port and the program-load port. During boot it gives the loader exclusive access and holds the core off. After boot it arbitrates both requesters onto the memory port, one access per cycle. Responses are routed back with fixed one-cycle latency, and misaligned or out-of-range accesses are converted into NOP responses.

## Interface
Parameters:
- DEPTH, 256: memory depth in 32-bit words; must be a power of two.
- AW, $clog2(DEPTH): width of the memory word index.
- NOP_WORD, 32'h00000013: data returned for faulted reads.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  32  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write enable (1 = write, 0 = read).
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader response (read data or write acknowledge).
- l_rdata  out  32  loader read data.
- boot_done  in  1  one-cycle pulse: program load is complete.
- core_run  out  1  core may fetch (high in RUN).
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory word index.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid the cycle after m_en.
- err  out  1  sticky access fault flag.

## Operation
- FSM states are BOOT (reset state) and RUN.
- BOOT → RUN on the clock edge where boot_done=1. There is no path from RUN back to BOOT except reset.
- In BOOT:
  - f_gnt=0 and core_run=0.
  - l_gnt=l_req.
- In RUN, requests are arbitrated per cycle:
  - Only one requester active: that requester is granted.
  - Both active: resolved by the policy (see Configuration).
- Grant decode is combinational from the requests, the state, and the arbitration pointer.
- The winner's address, we and wdata drive m_*:
  - m_addr = addr[AW+1:2].
  - m_we=1 only for a loader write.
  - Fetch is always a read.
- Fault: an access faults if addr[1:0]≠0 or addr[31:2]≥DEPTH.
  - A faulted access is still granted, but m_en=0 for it.
  - Its response is issued in the normal slot: rdata=NOP_WORD for reads, plain ack for writes.
  - err is set; it clears only on reset.
- Response routing:
  - A registered owner tag (none/fetch/loader) and a registered fault bit select the response for the next cycle.
  - f_rdata and l_rdata = m_rdata, or NOP_WORD if the fault bit is set.
  - An rdata output is don't-care when its rvalid is low.
  - A loader write produces l_rvalid one cycle later; l_rdata is undefined for writes.

## Timing
- Reset values:
  - State BOOT, owner none.
  - core_run=0, f_gnt=0, l_gnt=0, f_rvalid=0, l_rvalid=0, err=0.
  - m_en=0, m_we=0; m_addr and m_wdata are 0.
  - Arbitration pointer = fetch.
- Handshake: req is sampled combinationally and gnt is asserted in the same cycle. A requester not granted must hold req and its address/data stable until granted.
- Latency: grant in cycle N gives rvalid in cycle N+1. Throughput is one access per cycle, back-to-back, with no bubbles.
- boot_done together with l_req in the same cycle: the loader access is served as a BOOT access. core_run rises in the next cycle, where fetch becomes eligible.
- boot_done while already in RUN is ignored.
- Reset asserted mid-access: the pending response is dropped (no rvalid after reset release), and the arbiter restarts in BOOT.

## Configuration
- IMEM_ARB_RR_EN defined:
  - Round-robin arbitration on contention.
  - A one-bit pointer favours the requester that did not win the last contested cycle.
  - Uncontested grants do not move the pointer.
- Not defined:
  - Fixed priority, fetch wins all contested cycles.
  - The loader can starve while fetch requests continuously.
  - The pointer register is not implemented.

## Test plan
- Boot load:
  - Stimulus: in BOOT, loader writes 32'h00100093@0x0 and 32'h00200113@0x4, with f_req=1 held throughout.
  - Response: f_gnt=0 and core_run=0 throughout; l_rvalid one cycle after each grant.
  - Then pulse boot_done. The fetch of 0x0 returns f_rdata=32'h00100093 one cycle after f_gnt.
- Back-to-back fetch: in RUN, fetch 0x0, 0x4, 0x8 on consecutive cycles → three grants, then three consecutive f_rvalid with matching data.
- Contention, 4 cycles with f_req=l_req=1:
  - Fixed priority: f_gnt=1111, l_gnt=0000.
  - With IMEM_ARB_RR_EN: grants alternate, loader first.
- Faults:
  - f_addr=0x2 → m_en=0, f_rdata=32'h00000013, err=1.
  - l_addr=0x400 write (DEPTH=256) → no m_we, l_rvalid ack, err stays 1.
- Reset mid-op: assert rst_n=0 in the cycle after a grant → no rvalid appears, and state returns to BOOT with core_run=0.
- Edge case: boot_done and a loader write in the same cycle → the write completes, and f_gnt can first assert in the following cycle.
